xcore_seq_shifter: RTL
======================

# xcore_seq_shifter

Parametrised, multi-cycle shift/rotate unit for the Xcore datapath. It is the successor to the one-bit, two-control-line shift-cell mux: it generalises it to a WIDTH-bit register with eight operating modes and a shift count, and it adds a start/busy/done handshake. The unit shifts one bit position per clock. It sits beside the ALU and serves shift-class instructions, which stall on `busy`.

## Interface
- `WIDTH`, default 32: data width; must be ≥ 2.
- `SHAMT_W`, default 5: shift-amount width, equal to $clog2(WIDTH).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  3  mode, sampled with `start`: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101 SLS (shift left, fill with `ser_in`), 110 SRS (shift right, fill with `ser_in`), 111 PASS.
- `din`  in  WIDTH  operand, sampled with `start`.
- `shamt`  in  SHAMT_W  shift count, sampled with `start`; range 0..WIDTH-1.
- `ser_in`  in  1  fill bit for SLS/SRS, sampled on every shift step (not latched).
- `flush`  in  1  abort; takes priority over everything except `rst`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `dout` is valid in that cycle.
- `dout`  out  WIDTH  result register.

## Operation
- States: IDLE, SHIFT. `done` is a registered flag, not a state.
- **IDLE**
  - When `start`=1: `data`←`din`, `cnt`←`shamt`, `mode`←`op`, go to SHIFT, `busy`←1.
  - If `op`=111, `cnt`←0 regardless of `shamt`.
- **SHIFT**, per edge:
  - `cnt`≠0: `data`←step(`data`), `cnt`←`cnt`-1.
  - `cnt`=0: go to IDLE, `busy`←0, `done`←1.
- **step(d)** for each mode:
  - SLL: {d[W-2:0],0}
  - SRL: {0,d[W-1:1]}
  - SRA: {d[W-1],d[W-1:1]}
  - ROL: {d[W-2:0],d[W-1]}
  - ROR: {d[0],d[W-1:1]}
  - SLS: {d[W-2:0],`ser_in`}
  - SRS: {`ser_in`,d[W-1:1]}
- **done**: deasserts on the next edge unless another completion occurs on that edge.
- **dout**: mirrors `data`. It holds the result after `done` until the edge that accepts the next `start`.
- **start while busy=1**: ignored. No queueing, and no change to the in-flight operation.
- **start in the done cycle**: accepted, since `busy`=0 in that cycle. Back-to-back operations are legal.
- **flush=1**: next edge forces IDLE, `busy`←0, `done`←0, `cnt`←0. `dout` keeps its partial value. A `start` in the same cycle as `flush` is dropped.
- **rst=1**: next edge forces IDLE, `busy`=0, `done`=0, `dout`=0, `cnt`=0, `mode`=000. This applies mid-operation too; no `done` is produced.
- **Arithmetic**: `cnt` is SHAMT_W bits. `shamt`≥WIDTH (possible when WIDTH is not a power of 2) is clamped to WIDTH-1 on capture.

## Timing
- Count cycles from T, the cycle in which `start` is sampled high with `busy`=0.
- `busy` is high in cycles T+1 .. T+shamt+1.
- `done`=1 and the final `dout` appear in cycle T+shamt+2.
- Latency is `shamt`+2 cycles; PASS and `shamt`=0 both take 2 cycles.
- Throughput: one operation every `shamt`+2 cycles, issuing the next `start` in the done cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values**: after `rst`, outputs are `busy`=0, `done`=0, `dout`=0. Then SLL `din`=0x0000_0001, `shamt`=4 at T → `busy` high T+1..T+5, `done` at T+6, `dout`=0x0000_0010.
- **Right shifts**: SRA 0x8000_0000, `shamt`=31 → `dout`=0xFFFF_FFFF at T+33. SRL with the same operands → 0x0000_0001.
- **Rotates and PASS**:
  - ROR 0x0000_0001, `shamt`=1 → 0x8000_0000 at T+3.
  - ROL 0x8000_0001, `shamt`=4 → 0x0000_0018.
  - PASS 0xDEAD_BEEF, `shamt`=7 → `dout`=0xDEAD_BEEF at T+2.
- **Serial fill**: SLS 0x0, `shamt`=3, `ser_in` held 1 → 0x0000_0007. SRS with `ser_in` toggling 1,0,1 → 0xA000_0000.
- **Handshake**:
  - `start` pulsed during `busy` → ignored; the original result and timing are unchanged.
  - New `start` in the done cycle → second result appears at its own T+shamt+2.
  - `shamt`=0 → `done` at T+2 with `dout`=`din`.
- **Abort**:
  - `flush` at T+3 of a 10-step operation → `busy`=0 at T+4, and no `done` appears afterwards.
  - `rst` mid-operation → `dout`=0, no `done`.
  - A `start` after either recovers and completes normally.

Source files
------------

// File: rtl/xcore_seq_shifter.sv
// xcore_seq_shifter: multi-cycle shift/rotate unit, one bit position per clock.
// Ports: clk, rst (sync, active-high), start/op/din/shamt request,
//   ser_in serial fill bit, flush abort, busy/done/dout registered results.
module xcore_seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               ser_in,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_SLS  = 3'b101;
  localparam logic [2:0] OP_SRS  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [SHAMT_W-1:0] CNT_MAX = SHAMT_W'(WIDTH - 1);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] cnt;
  logic [2:0]         mode;

  logic [WIDTH-1:0]   stepped;
  logic [SHAMT_W-1:0] cnt_init;

  assign dout = data;

  // One-position step of the held operand in the captured mode.
  always_comb begin
    stepped = data;
    case (mode)
      OP_SLL:  stepped = {data[WIDTH-2:0], 1'b0};
      OP_SRL:  stepped = {1'b0, data[WIDTH-1:1]};
      OP_SRA:  stepped = {data[WIDTH-1], data[WIDTH-1:1]};
      OP_ROL:  stepped = {data[WIDTH-2:0], data[WIDTH-1]};
      OP_ROR:  stepped = {data[0], data[WIDTH-1:1]};
      OP_SLS:  stepped = {data[WIDTH-2:0], ser_in};
      OP_SRS:  stepped = {ser_in, data[WIDTH-1:1]};
      default: stepped = data;
    endcase
  end

  // PASS never steps; oversized counts (non power-of-2 WIDTH) clamp.
  always_comb begin
    cnt_init = shamt;
    if (op == OP_PASS)
      cnt_init = '0;
    else if (shamt > CNT_MAX)
      cnt_init = CNT_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      data  <= '0;
      cnt   <= '0;
      mode  <= OP_SLL;
    end else if (flush) begin
      // Partial data stays visible on dout.
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            data  <= din;
            cnt   <= cnt_init;
            mode  <= op;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            data <= stepped;
            cnt  <= cnt - CNT_ONE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
